disp_hex_mux: RTL and testbench
===============================

Name: disp_hex_mux

Overview:
Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display. It consumes the BCD digits and the no_ammo flag from the ammo counter, plus the two score digits. It scans one digit per refresh slot and blanks the ammo tens digit when that digit is a leading zero. While no_ammo is high, the ammo digits blink. It sits between the game control logic and the top-level display pins.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 ms per digit, 250 Hz frame rate).
BLINK_FRAMES, 64, full 4-digit frames per blink half-period.
BLANK_LEADING, 1, when 1 the ammo tens digit is blanked if it is 0.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
hex0  in  4  ammo ones digit (0-9)
hex1  in  4  ammo tens digit (0-9)
hex2  in  4  score ones digit
hex3  in  4  score tens digit
no_ammo  in  1  level; enables blinking of digits 0-1
sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  4  digit anodes, active-low, one-hot-low; an[i] selects digit i
dp  out  1  decimal point, active-low, held at 1 (off)

Behaviour:
- Reset is asynchronous and active-low; one clock. While rst_n=0:
  - an=4'b1111, sseg=7'b1111111, dp=1.
  - Refresh counter, digit select, frame counter, blink phase and snapshot registers all = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle is the "tick".
- Digit select sel[1:0]:
  - Advances 0→1→2→3→0 on each tick.
- Snapshot:
  - On the tick where sel goes 3→0, hex0..hex3 and no_ammo are captured into shadow registers.
  - Capture also happens on the first clock after reset release.
  - Displayed values change only at frame boundaries, so a mid-frame decrement from the ammo counter never tears.
- Blink:
  - The frame counter increments on each 3→0 tick and wraps at BLINK_FRAMES-1.
  - On that wrap, blink_phase toggles.
  - When snapshot no_ammo=1 and blink_phase=1, digits 0 and 1 are blanked (all segments off, anode still driven).
  - When snapshot no_ammo=0, blink_phase is forced to 0 and the frame counter is cleared. The next blink therefore always starts with digits visible.
- Leading-zero blanking:
  - If BLANK_LEADING=1 and snapshot hex1==0, digit 1 is blank.
  - Digit 0 is never blanked by this rule, so 0 ammo shows "0".
  - Score digits are never leading-blanked.
- Decode:
  - Values 0-9 map to standard glyphs; 10-15 map to A,b,C,d,E,F.
  - Glyph examples: 0→1000000, 1→1111001, 6→0000010, blank→1111111.
- Output timing:
  - an and sseg are registered.
  - They reflect the new sel exactly 1 cycle after the tick.
  - an and sseg change in the same cycle, so there is no ghosting cycle.
- Digit slots:
  - Each digit is driven for exactly REFRESH_DIV cycles.
  - One frame = 4×REFRESH_DIV cycles.
- Input changes mid-slot are ignored until the next frame snapshot.
- Reset asserted mid-frame blanks outputs immediately (asynchronous). After release, scanning restarts at digit 0.

Decomposition:
- Shared package disp_pkg holds:
  - SEG_BLANK constant.
  - Glyph constants for 0-F.
  - typedef digit_sel_t (2-bit).
  - An_of(sel) helper constant table.
- One natural sub-module: disp_hex2sseg, a purely combinational 4-bit to 7-segment decoder with a blank input. It is instantiated once after the select mux.
- Counters and FSM-free scan logic stay in disp_hex_mux.

Test Plan:
- Test parameters for all scenarios: REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset then release with hex3..0=1,2,1,6 and no_ammo=0:
  - an cycles 1110,1101,1011,0111 with 4 cycles each.
  - sseg shows 0000010 (6), then 1111001 (1), then the glyphs for 2 and 1.
- hex1=0, hex0=7 → digit 1 slot shows sseg=1111111 with an=1101; digit 0 shows 7 (1111000).
- hex1=0, hex0=0, no_ammo=1:
  - Frames 0-1 show "0" on digit 0.
  - Frames 2-3 blank digits 0-1.
  - Score digits stay lit throughout.
  - no_ammo deasserted mid-blink → digits visible from the next frame.
- Change hex0 from 6 to 5 during the digit-2 slot → digit 0 still shows 6 for the rest of the frame and shows 5 in the next frame.
- Assert rst_n=0 mid digit-1 slot → an=1111 and sseg=1111111 in the same cycle, without waiting for clk. After release, the first driven digit is an=1110.
- hex0=4'hA → sseg=0001000 ('A') on digit 0, confirming the hex extension of the decoder.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display driver: glyph table,
// blank pattern, digit-select type and the anode lookup.
package disp_pkg;

    typedef logic [1:0] digit_sel_t;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] GLYPH_A   = 7'b0001000;
    localparam logic [6:0] GLYPH_B   = 7'b0000011;
    localparam logic [6:0] GLYPH_C   = 7'b1000110;
    localparam logic [6:0] GLYPH_D   = 7'b0100001;
    localparam logic [6:0] GLYPH_E   = 7'b0000110;
    localparam logic [6:0] GLYPH_F   = 7'b0001110;

    // Active-low one-hot anode pattern for a digit select value.
    function automatic logic [3:0] an_of(input digit_sel_t sel);
        logic [3:0] an;
        case (sel)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/disp_hex2sseg.sv
// Combinational hex-to-seven-segment decoder with a blank override.
module disp_hex2sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] sseg
);

    // Map the nibble to its glyph, or turn all segments off when blanked.
    always_comb begin
        sseg = SEG_BLANK;
        if (!blank) begin
            case (hex)
                4'h0:    sseg = GLYPH_0;
                4'h1:    sseg = GLYPH_1;
                4'h2:    sseg = GLYPH_2;
                4'h3:    sseg = GLYPH_3;
                4'h4:    sseg = GLYPH_4;
                4'h5:    sseg = GLYPH_5;
                4'h6:    sseg = GLYPH_6;
                4'h7:    sseg = GLYPH_7;
                4'h8:    sseg = GLYPH_8;
                4'h9:    sseg = GLYPH_9;
                4'hA:    sseg = GLYPH_A;
                4'hB:    sseg = GLYPH_B;
                4'hC:    sseg = GLYPH_C;
                4'hD:    sseg = GLYPH_D;
                4'hE:    sseg = GLYPH_E;
                default: sseg = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/disp_hex_mux.sv
// Time-multiplexed driver for the 4-digit common-anode display: scans one
// digit per refresh slot, snapshots inputs once per frame, blanks a leading
// zero on the ammo tens digit and blinks the ammo digits when out of ammo.
module disp_hex_mux
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_FRAMES  = 64,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    input  logic       no_ammo,
    output logic [6:0] sseg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic             started;
    logic [CNT_W-1:0] cnt;
    digit_sel_t       sel;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;
    logic [3:0]       snap_hex0;
    logic [3:0]       snap_hex1;
    logic [3:0]       snap_hex2;
    logic [3:0]       snap_hex3;
    logic             snap_no_ammo;
    logic             tick;
    logic             frame_tick;
    logic             blink_off;
    logic [3:0]       cur_hex;
    logic             cur_blank;
    logic [6:0]       dec_sseg;

    assign tick       = started && (cnt == CNT_LAST);
    assign frame_tick = tick && (sel == 2'd3);
    assign blink_off  = snap_no_ammo && blink_phase;
    assign dp         = 1'b1;

    // The first clock after reset only loads the snapshot, so the first slot is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Refresh counter and digit select; each digit owns REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel <= 2'd0;
        end else if (started) begin
            if (tick) begin
                cnt <= '0;
                sel <= sel + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Inputs are captured only at frame boundaries so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_hex0    <= 4'd0;
            snap_hex1    <= 4'd0;
            snap_hex2    <= 4'd0;
            snap_hex3    <= 4'd0;
            snap_no_ammo <= 1'b0;
        end else if (!started || frame_tick) begin
            snap_hex0    <= hex0;
            snap_hex1    <= hex1;
            snap_hex2    <= hex2;
            snap_hex3    <= hex3;
            snap_no_ammo <= no_ammo;
        end
    end

    // Blink timing is held cleared while not out of ammo, so every blink run starts visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!snap_no_ammo) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Pick the digit for the current slot and decide whether it is blanked.
    always_comb begin
        cur_hex   = snap_hex0;
        cur_blank = 1'b0;
        case (sel)
            2'd0: begin
                cur_hex   = snap_hex0;
                cur_blank = blink_off;
            end
            2'd1: begin
                cur_hex   = snap_hex1;
                cur_blank = blink_off || ((BLANK_LEADING != 0) && (snap_hex1 == 4'd0));
            end
            2'd2: begin
                cur_hex = snap_hex2;
            end
            default: begin
                cur_hex = snap_hex3;
            end
        endcase
    end

    disp_hex2sseg u_dec (
        .hex   (cur_hex),
        .blank (cur_blank),
        .sseg  (dec_sseg)
    );

    // Anode and segments are registered together so they switch in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= 4'b1111;
            sseg <= SEG_BLANK;
        end else if (started) begin
            an   <= an_of(sel);
            sseg <= dec_sseg;
        end
    end

endmodule

// File: tb/tb_disp_hex_mux.sv
// Self-checking bench for disp_hex_mux with a frame-level reference model.
module tb_disp_hex_mux;

    localparam int R     = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * R;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hex0 = 4'd0;
    logic [3:0] hex1 = 4'd0;
    logic [3:0] hex2 = 4'd0;
    logic [3:0] hex3 = 4'd0;
    logic       no_ammo = 1'b0;
    logic [6:0] sseg;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;

    int         k = 0;
    logic [3:0] m_hex [4];
    logic       m_na = 1'b0;
    int         run_len = 0;
    logic [6:0] exp_sseg;
    logic [3:0] exp_an;

    disp_hex_mux #(
        .REFRESH_DIV   (R),
        .BLINK_FRAMES  (BF),
        .BLANK_LEADING (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .no_ammo (no_ammo),
        .sseg    (sseg),
        .an      (an),
        .dp      (dp)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    task automatic check_output(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] h3, input logic [3:0] h2,
                                  input logic [3:0] h1, input logic [3:0] h0,
                                  input logic na);
        hex3    = h3;
        hex2    = h2;
        hex1    = h1;
        hex0    = h0;
        no_ammo = na;
    endtask

    // One clock: predict outputs from the frame snapshot, capture at frame starts, then compare.
    task automatic step(input string tag);
        int   d;
        logic blink;
        logic blank;
        @(posedge clk);
        exp_an   = 4'b1111;
        exp_sseg = 7'b1111111;
        if (rst_n) begin
            k++;
            if (k >= 2) begin
                d        = ((k - 2) / R) % 4;
                blink    = m_na && ((((run_len - 1) / BF) % 2) == 1);
                blank    = (d == 0) ? blink : (d == 1) ? (blink || (m_hex[1] == 4'd0)) : 1'b0;
                exp_an[d] = 1'b0;
                exp_sseg = blank ? 7'b1111111 : glyph(m_hex[d]);
            end
            if (((k - 1) % FRAME) == 0) begin
                m_hex[0] = hex0;
                m_hex[1] = hex1;
                m_hex[2] = hex2;
                m_hex[3] = hex3;
                run_len  = no_ammo ? (m_na ? run_len + 1 : 1) : 0;
                m_na     = no_ammo;
            end
        end
        #1;
        check_output({tag, " an"}, {3'b000, an}, {3'b000, exp_an});
        check_output({tag, " sseg"}, sseg, exp_sseg);
        check_output({tag, " dp"}, {6'd0, dp}, 7'd1);
    endtask

    task automatic run_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Step until the outputs show the requested digit slot (bounded).
    task automatic seek_digit(input int target);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (k >= 2 && (((k - 2) / R) % 4) == target) break;
            step("seek");
        end
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus(4'd1, 4'd2, 4'd1, 4'd6, 1'b0);
        run_cycles("in_reset", 2);
        #1 rst_n = 1'b1;

        // Scan order and glyphs for score 12, ammo 16.
        step("first_clock");
        step("digit0_first");
        check_output("digit0_an", {3'b000, an}, 7'b0001110);
        check_output("digit0_six", sseg, 7'b0000010);
        run_cycles("scan", 4);
        check_output("digit1_an", {3'b000, an}, 7'b0001101);
        check_output("digit1_one", sseg, 7'b1111001);
        run_cycles("scan", 2 * FRAME);

        // Leading-zero ammo tens digit.
        apply_stimulus(4'd1, 4'd2, 4'd0, 4'd7, 1'b0);
        run_cycles("lead_zero", 3 * FRAME);

        // Out of ammo: visible, then blinking, then released mid-blink.
        apply_stimulus(4'd3, 4'd4, 4'd0, 4'd0, 1'b1);
        run_cycles("no_ammo", 5 * FRAME + 6);
        apply_stimulus(4'd3, 4'd4, 4'd0, 4'd0, 1'b0);
        run_cycles("ammo_back", 2 * FRAME);

        // Mid-frame change must wait for the next frame.
        apply_stimulus(4'd2, 4'd5, 4'd1, 4'd6, 1'b0);
        run_cycles("pre_tear", FRAME);
        seek_digit(2);
        apply_stimulus(4'd2, 4'd5, 4'd1, 4'd5, 1'b0);
        run_cycles("no_tear", 2 * FRAME);

        // Asynchronous reset in the middle of the digit 1 slot.
        seek_digit(1);
        rst_n = 1'b0;
        #1;
        check_output("async_an", {3'b000, an}, 7'b0001111);
        check_output("async_sseg", sseg, 7'b1111111);
        k       = 0;
        m_na    = 1'b0;
        run_len = 0;
        run_cycles("held_reset", 2);
        #1 rst_n = 1'b1;
        step("restart_first");
        step("restart_digit0");
        check_output("restart_an", {3'b000, an}, 7'b0001110);

        // Hex extension on the ammo ones digit.
        apply_stimulus(4'd9, 4'd8, 4'd3, 4'hA, 1'b0);
        run_cycles("hex_a", 2 * FRAME);

        // Randomized inputs, changed at arbitrary points within frames.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) no_ammo = ~no_ammo;
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    hex0 = 4'($urandom_range(0, 15));
                    hex1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    hex2 = 4'($urandom_range(0, 15));
                    hex3 = 4'($urandom_range(0, 15));
                end
                step("random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
